alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_mul_iter.sv | 67 ++++++
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the sequential ALU: opcode values,
//                FSM state encoding and bit positions inside the flags word.
//  Contents    : OP_* opcode constants, state_t enum, FLAG_* indices,
//                is_defined_op() helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encoding (4-bit opcode field).
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;

    // Bit positions inside the 5-bit flags word {ERR,V,N,Z,C}.
    localparam int FLAG_C   = 0;
    localparam int FLAG_Z   = 1;
    localparam int FLAG_N   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_ERR = 4;
    localparam int FLAGS_W  = 5;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes 12..15 are reserved and produce an error result.
    function automatic logic is_defined_op(input logic [3:0] op);
        return (op <= OP_CMP);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_iter
//  Description : Iterative shift-add multiplier returning the low WIDTH bits
//                of a*b. One multiplier bit is consumed per clock, WIDTH
//                clocks in total; the first bit is consumed on the start edge
//                so that done is presented during the WIDTH-th clock.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                start       - load operands a/b and begin (one-cycle pulse)
//                a, b        - multiplicand / multiplier
//                done        - product valid this cycle (one-cycle pulse)
//                product     - low WIDTH bits of a*b
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             active;

    // Only the low WIDTH bits of the product are kept, so partial products
    // shifted beyond the top bit are simply dropped by the shifting mcand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
            count  <= CW'(WIDTH - 1);
            active <= 1'b1;
        end else if (active) begin
            if (count != '0) begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - 1'b1;
            end else begin
                // Product consumed by the controller on this edge.
                active <= 1'b0;
            end
        end
    end

    assign done    = active && (count == '0);
    assign product = acc;

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential ALU with valid/ready handshakes on both sides.
//                Single-cycle operations are computed combinationally from
//                the live inputs and registered on the accept edge; MUL is
//                handed to the iterative multiplier and completes WIDTH
//                cycles later. Results are held until the consumer accepts.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid / in_ready - operation handshake
//                opcode, A, B        - operation select and operands
//                out_valid/out_ready - result handshake
//                D                   - registered result
//                flags               - registered {ERR,V,N,Z,C}, C at bit 0
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic [4:0]       flags
);

    localparam int MSB = WIDTH - 1;

    state_t           state;
    logic             c_reg;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             carry_in;

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             res_err;
    logic [WIDTH-1:0] d_next;
    logic [4:0]       flags_next;
    logic [4:0]       mul_flags;

    // in_ready is a registered copy of "state == IDLE".
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MUL);

    // ------------------------------------------------------------------
    // Iterative multiplier
    // ------------------------------------------------------------------
    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign carry_in = (opcode == OP_ADC) ? c_reg : 1'b0;
    assign add_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carry_in};
    // Subtraction as A + ~B + 1 so the carry out reads as "no borrow".
    assign sub_sum  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (opcode)
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_NOT: res = ~A;
            OP_XOR: res = A ^ B;
            OP_ADD, OP_ADC: begin
                res   = add_sum[MSB:0];
                res_c = add_sum[WIDTH];
                res_v = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
            end
            OP_SUB, OP_CMP: begin
                res   = sub_sum[MSB:0];
                res_c = sub_sum[WIDTH];
                res_v = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
            end
            OP_LSL: begin
                res   = {A[MSB-1:0], 1'b0};
                res_c = A[MSB];
            end
            OP_LSR: begin
                res   = {1'b0, A[MSB:1]};
                res_c = A[0];
            end
            OP_ASR: begin
                res   = {A[MSB], A[MSB:1]};
                res_c = A[0];
            end
            // MUL result comes from the multiplier; nothing to do here.
            OP_MUL: res = '0;
            default: res_err = 1'b1;
        endcase
        // Reserved opcodes leave res at zero, giving Z=1 and N=0.
        if (!is_defined_op(opcode)) begin
            res_err = 1'b1;
        end
    end

    // CMP presents A on D but its Z/N still describe the difference.
    always_comb begin
        d_next               = (opcode == OP_CMP) ? A : res;
        flags_next           = '0;
        flags_next[FLAG_C]   = res_c;
        flags_next[FLAG_Z]   = (res == '0);
        flags_next[FLAG_N]   = res[MSB];
        flags_next[FLAG_V]   = res_v;
        flags_next[FLAG_ERR] = res_err;
    end

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_product == '0);
        mul_flags[FLAG_N] = mul_product[MSB];
    end

    // ------------------------------------------------------------------
    // Handshake FSM with registered outputs. C_reg follows the C flag of
    // every result that enters DONE, and only then.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D         <= '0;
            flags     <= '0;
            c_reg     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (opcode == OP_MUL) begin
                            state <= ST_BUSY;
                        end else begin
                            D         <= d_next;
                            flags     <= flags_next;
                            c_reg     <= flags_next[FLAG_C];
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        D         <= mul_product;
                        flags     <= mul_flags;
                        c_reg     <= mul_flags[FLAG_C];
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE here means no accept can coincide
                    // with the result being consumed.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : alu_seq
`default_nettype wire
